hazard_detection_unit: RTL and testbench

// Pipeline hazard controller for the 5-stage RV32I core; sits in ID, upstream of

---
 rtl/hazard_detection_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_detection_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles, EX branch flushes,
// data-memory wait freezes with a watchdog, plus saturating stall/flush counters.
module hazard_detection_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_addr_i,
  input  logic [4:0]       ID_Rs2_addr_i,
  input  logic             ID_rs1_used_i,
  input  logic             ID_rs2_used_i,
  input  logic [4:0]       ID_EX_Rd_i,
  input  logic             ID_EX_mem_rd_en_i,
  input  logic             EX_br_taken_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ack_i,
  output logic             PC_en_o,
  output logic             IF_ID_en_o,
  output logic             ID_EX_en_o,
  output logic             EX_MEM_en_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             MEM_WB_flush_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       fsm_state_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic frozen;
  logic br_flush;

  always_comb begin
    load_use = ID_EX_mem_rd_en_i && (ID_EX_Rd_i != 5'd0) &&
               ((ID_rs1_used_i && (ID_EX_Rd_i == ID_Rs1_addr_i)) ||
                (ID_rs2_used_i && (ID_EX_Rd_i == ID_Rs2_addr_i)));
  end

  // Handshake with data memory: MEM_req_i marks an access in MEM; the access completes
  // in the cycle MEM_ack_i is high. Until then the whole front of the pipe holds still.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    frozen         = 1'b0;
    br_flush       = 1'b0;
    PC_en_o        = 1'b1;
    IF_ID_en_o     = 1'b1;
    ID_EX_en_o     = 1'b1;
    EX_MEM_en_o    = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_flush_o  = 1'b0;
    MEM_WB_flush_o = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        frozen = (state_q == ST_MEM_WAIT) ? !MEM_ack_i : (MEM_req_i && !MEM_ack_i);
        if (frozen) begin
          PC_en_o        = 1'b0;
          IF_ID_en_o     = 1'b0;
          ID_EX_en_o     = 1'b0;
          EX_MEM_en_o    = 1'b0;
          MEM_WB_flush_o = 1'b1;
          if (state_q == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if ((MEM_TIMEOUT != 0) && (wait_cnt_d >= TIMEOUT_V)) begin
              state_d = ST_HALT;
            end
          end
        end else begin
          // Completed access releases the freeze; EX/ID hazards held so far are acted on now.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (EX_br_taken_i) begin
            IF_ID_flush_o = 1'b1;
            ID_EX_flush_o = 1'b1;
            br_flush      = 1'b1;
          end else if (load_use) begin
            PC_en_o       = 1'b0;
            IF_ID_en_o    = 1'b0;
            ID_EX_flush_o = 1'b1;
          end
        end
        if (!PC_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (br_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d        = ST_HALT;
        PC_en_o        = 1'b0;
        IF_ID_en_o     = 1'b0;
        ID_EX_en_o     = 1'b0;
        EX_MEM_en_o    = 1'b0;
        MEM_WB_flush_o = 1'b1;
      end
    endcase

    if (rst_i) begin
      PC_en_o        = 1'b0;
      IF_ID_en_o     = 1'b0;
      ID_EX_en_o     = 1'b0;
      EX_MEM_en_o    = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_flush_o  = 1'b1;
      MEM_WB_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err_o   = (state_q == ST_HALT) && !rst_i;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a behavioural model predicts every control
// output and counter each cycle, with literal spot checks at the interesting points.
module tb_hazard_detection_unit;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             rs1_used, rs2_used, ex_load, br_taken, mem_req, mem_ack;
  logic             PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o;
  logic             IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o, mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]       fsm_state_o;
  logic [7:0]       dut_ctl;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  // Model: frozen-cycle run length, halted flag, saturating counters.
  bit m_halted     = 1'b0;
  int m_frozen_run = 0;
  int m_stalls     = 0;
  int m_flushes    = 0;

  hazard_detection_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Rs1_addr_i(id_rs1), .ID_Rs2_addr_i(id_rs2),
    .ID_rs1_used_i(rs1_used), .ID_rs2_used_i(rs2_used),
    .ID_EX_Rd_i(ex_rd), .ID_EX_mem_rd_en_i(ex_load),
    .EX_br_taken_i(br_taken), .MEM_req_i(mem_req), .MEM_ack_i(mem_ack),
    .PC_en_o(PC_en_o), .IF_ID_en_o(IF_ID_en_o), .ID_EX_en_o(ID_EX_en_o),
    .EX_MEM_en_o(EX_MEM_en_o), .IF_ID_flush_o(IF_ID_flush_o),
    .ID_EX_flush_o(ID_EX_flush_o), .MEM_WB_flush_o(MEM_WB_flush_o),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .fsm_state_o(fsm_state_o)
  );

  assign dut_ctl = {PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o,
                    IF_ID_flush_o, ID_EX_flush_o, MEM_WB_flush_o, mem_err_o};

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoring ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Bit order {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, mem_wb_fl, err}
  function automatic logic [7:0] model_ctl();
    logic lu, frz;
    lu  = ex_load && (ex_rd != 5'd0) &&
          ((rs1_used && ex_rd == id_rs1) || (rs2_used && ex_rd == id_rs2));
    frz = (m_frozen_run > 0) ? !mem_ack : (mem_req && !mem_ack);
    if (rst_i)    return 8'b0000_1110;
    if (m_halted) return 8'b0000_0011;
    if (frz)      return 8'b0000_0010;
    if (br_taken) return 8'b1111_1100;
    if (lu)       return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  always @(posedge clk_i) begin
    logic [7:0] c;
    c = model_ctl();
    if (rst_i) begin
      m_halted     = 1'b0;
      m_frozen_run = 0;
      m_stalls     = 0;
      m_flushes    = 0;
    end else if (!m_halted) begin
      if (!c[7] && m_stalls < MAXC) m_stalls++;
      if (c[3] && m_flushes < MAXC) m_flushes++;
      if (!c[4]) begin
        m_frozen_run++;
        if (m_frozen_run == MEM_TIMEOUT) m_halted = 1'b1;
      end else begin
        m_frozen_run = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_on) begin
      check("ctl", {24'b0, dut_ctl}, {24'b0, model_ctl()});
      check("stall_cnt", 32'(stall_cnt_o), m_stalls);
      check("flush_cnt", 32'(flush_cnt_o), m_flushes);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    ex_rd = 5'd0; ex_load = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic set_ex(input logic load, input logic [4:0] rd);
    ex_load = load;
    ex_rd   = rd;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_rs1 = r1; rs1_used = u1; id_rs2 = r2; rs2_used = u2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_i = 1'b1;
    idle();
    step();
    cmp_on = 1'b1;
    step(2);
    check_bit("rst_pc_en", PC_en_o, 1'b0);
    check_bit("rst_ifid_flush", IF_ID_flush_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("rst_stall_cnt", 32'(stall_cnt_o), 0);
    check("rst_flush_cnt", 32'(flush_cnt_o), 0);
    check_bit("idle_pc_en", PC_en_o, 1'b1);
    step();

    // lw x5 in EX, add reading x5 in ID: one bubble
    set_ex(1'b1, 5'd5); set_id(5'd5, 1'b1, 5'd0, 1'b0); #1;
    check_bit("lu_pc_en", PC_en_o, 1'b0);
    check_bit("lu_idex_flush", ID_EX_flush_o, 1'b1);
    step();
    set_ex(1'b0, 5'd0); #1;
    check_bit("lu_release", PC_en_o, 1'b1);
    check("lu_stall_cnt", 32'(stall_cnt_o), 1);
    step();

    // lw x0 never stalls; rs2 match with rs2 unused never stalls
    set_ex(1'b1, 5'd0); set_id(5'd0, 1'b1, 5'd0, 1'b1); #1;
    check_bit("x0_no_stall", PC_en_o, 1'b1);
    set_ex(1'b1, 5'd5); set_id(5'd3, 1'b1, 5'd5, 1'b0); #1;
    check_bit("rs2_unused_no_stall", PC_en_o, 1'b1);
    step();

    // branch taken wins over load-use
    set_ex(1'b1, 5'd7); set_id(5'd7, 1'b1, 5'd0, 1'b0); br_taken = 1'b1; #1;
    check_bit("br_ifid_flush", IF_ID_flush_o, 1'b1);
    check_bit("br_idex_flush", ID_EX_flush_o, 1'b1);
    check_bit("br_pc_en", PC_en_o, 1'b1);
    step();
    idle(); #1;
    check("br_flush_cnt", 32'(flush_cnt_o), 1);
    step();

    // memory wait, ack on 4th cycle; branch held in EX acted on at release
    mem_req = 1'b1; mem_ack = 1'b0; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("mw_memwb_flush", MEM_WB_flush_o, 1'b1);
      check_bit("mw_pc_en", PC_en_o, 1'b0);
      check_bit("mw_no_br_flush", IF_ID_flush_o, 1'b0);
      step();
    end
    mem_ack = 1'b1; #1;
    check_bit("mw_ack_pc_en", PC_en_o, 1'b1);
    check_bit("mw_ack_memwb", MEM_WB_flush_o, 1'b0);
    check_bit("mw_ack_br_flush", IF_ID_flush_o, 1'b1);
    step();
    idle(); #1;
    check("mw_stall_cnt", 32'(stall_cnt_o), 4);
    check("mw_flush_cnt", 32'(flush_cnt_o), 2);
    step();

    // lw x6; lw x7,0(x6); add uses x7: each load stalls once
    set_ex(1'b1, 5'd6); set_id(5'd6, 1'b1, 5'd0, 1'b0); step();
    set_ex(1'b0, 5'd0); step();
    set_ex(1'b1, 5'd7); set_id(5'd7, 1'b1, 5'd1, 1'b1); step();
    set_ex(1'b0, 5'd0); step();
    idle(); #1;
    check("b2b_stall_cnt", 32'(stall_cnt_o), 6);

    // saturation of both counters
    for (int i = 0; i < 20; i++) begin
      set_ex(1'b1, 5'd9); set_id(5'd2, 1'b0, 5'd9, 1'b1); step();
      idle(); step();
    end
    check("sat_stall_cnt", 32'(stall_cnt_o), 15);
    for (int i = 0; i < 20; i++) begin
      br_taken = 1'b1; step();
    end
    br_taken = 1'b0; #1;
    check("sat_flush_cnt", 32'(flush_cnt_o), 15);
    step();

    // reset in the middle of a memory wait
    mem_req = 1'b1; mem_ack = 1'b0; step(3);
    rst_i = 1'b1; #1;
    check_bit("rst_mid_idex_flush", ID_EX_flush_o, 1'b1);
    step();
    rst_i = 1'b0; idle(); #1;
    check("rst_mid_stall_cnt", 32'(stall_cnt_o), 0);
    check("rst_mid_flush_cnt", 32'(flush_cnt_o), 0);
    check_bit("rst_mid_pc_en", PC_en_o, 1'b1);
    step();

    // watchdog: 16 frozen cycles, then HALT until reset
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      check_bit("wd_err_before", mem_err_o, 1'b0);
      step();
    end
    check_bit("wd_err_set", mem_err_o, 1'b1);
    check_bit("wd_halt_pc_en", PC_en_o, 1'b0);
    check_bit("wd_halt_memwb", MEM_WB_flush_o, 1'b1);
    mem_req = 1'b0; mem_ack = 1'b1; step(3);
    check_bit("wd_err_sticky", mem_err_o, 1'b1);
    check_bit("wd_halt_exmem_en", EX_MEM_en_o, 1'b0);
    check("wd_stall_cnt", 32'(stall_cnt_o), 15);
    rst_i = 1'b1; step();
    rst_i = 1'b0; idle(); #1;
    check_bit("wd_err_cleared", mem_err_o, 1'b0);
    check_bit("wd_pc_en_after_rst", PC_en_o, 1'b1);
    step(2);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
